// File: rtl/canny_sobel_stream.sv
// Streaming Sobel gradient stage: two line buffers, 3x3 window, saturated |Gx|+|Gy| and 2-bit direction.
// Define CANNY_SOBEL_DIR_EN to build the direction quantiser; otherwise out_dir is tied to 0.
module canny_sobel_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_mag,
  output logic [1:0]       out_dir,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW   = PIX_W + 2;
  localparam int GW   = PIX_W + 3;
  localparam int SATW = (MAG_W > GW) ? MAG_W : GW;

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
    return v[GW-1] ? -v : v;
  endfunction

  function automatic logic [MAG_W-1:0] sat_mag(input logic [GW-1:0] m);
    logic [SATW-1:0] me;
    logic [SATW-1:0] lim;
    me  = SATW'(m);
    lim = SATW'({MAG_W{1'b1}});
    return (me > lim) ? {MAG_W{1'b1}} : me[MAG_W-1:0];
  endfunction

`ifdef CANNY_SOBEL_DIR_EN
  // Ratio thresholds 2/5 and 5/2 approximate tan(22.5) and tan(67.5) without a divider.
  function automatic logic [1:0] quant_dir(input logic signed [GW-1:0] gx, input logic signed [GW-1:0] gy,
                                           input logic [GW-1:0] ax, input logic [GW-1:0] ay);
    logic [GW+2:0] ax5, ay5, ax2, ay2;
    ax5 = {3'b000, ax} + {1'b0, ax, 2'b00};
    ay5 = {3'b000, ay} + {1'b0, ay, 2'b00};
    ax2 = {2'b00, ax, 1'b0};
    ay2 = {2'b00, ay, 1'b0};
    if (gx == '0 && gy == '0) return 2'd0;
    else if (ay5 < ax2)       return 2'd0;
    else if (ay2 > ax5)       return 2'd2;
    else if (gx[GW-1] == gy[GW-1]) return 2'd1;
    else                      return 2'd3;
  endfunction
`endif

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic             accept, load;
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] new_col [3];
  logic [SW-1:0]    sum_l, sum_r, sum_t, sum_b;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]    ax, ay, mag_sum;
  logic [MAG_W-1:0] mag_d;
  logic [1:0]       dir_d;
  logic             eol_d, eof_d;

  logic             out_valid_q;
  logic [MAG_W-1:0] out_mag_q;
  logic [1:0]       out_dir_q;
  logic             out_eol_q, out_eof_q;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Position tracking: in_sof pins the current pixel to (0,0)
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
    load  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    eol_d = (cur_col == CW'(IMG_W - 1));
    eof_d = eol_d && (cur_row == RW'(IMG_H - 1));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= in_pix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= new_col[r];
      end
    end
  end

  // Gradient: window right column is the incoming column, not yet registered
  always_comb begin
    new_col[0] = lb1_q[cur_col];
    new_col[1] = lb0_q[cur_col];
    new_col[2] = in_pix;
    sum_l   = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
    sum_r   = wsum(new_col[0], new_col[1], new_col[2]);
    sum_t   = wsum(win_q[0][0], win_q[0][1], new_col[0]);
    sum_b   = wsum(win_q[2][0], win_q[2][1], new_col[2]);
    gx      = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    gy      = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
    ax      = abs_g(gx);
    ay      = abs_g(gy);
    mag_sum = ax + ay;
    mag_d   = sat_mag(mag_sum);
`ifdef CANNY_SOBEL_DIR_EN
    dir_d   = quant_dir(gx, gy, ax, ay);
`else
    dir_d   = 2'b00;
`endif
  end

  // Output register: load wins over drain so a full stream sustains one result per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_dir_q   <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_mag_q   <= mag_d;
      out_dir_q   <= dir_d;
      out_eol_q   <= eol_d;
      out_eof_q   <= eof_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_dir   = out_dir_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_canny_sobel_stream.sv
// Scoreboard bench for canny_sobel_stream on an 8x6 image.
module tb_canny_sobel_stream;
  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int MAG_W = 8;
  localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);
`ifdef CANNY_SOBEL_DIR_EN
  localparam int DIR_H = 2;
  localparam int DIR_D = 3;
`else
  localparam int DIR_H = 0;
  localparam int DIR_D = 0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W-1:0] out_mag;
  logic [1:0]       out_dir;
  logic             out_eol;
  logic             out_eof;

  canny_sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .MAG_W(MAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
    .out_dir(out_dir), .out_eol(out_eol), .out_eof(out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mag;
    logic [1:0] dir;
    logic       eol;
    logic       eof;
  } res_t;

  res_t exp_q[$];
  res_t log_q[$];
  res_t ref_q[$];
  int   img[IMG_H][IMG_W];
  int   mr, mc;
  int   n_tests, n_fail;

  function automatic res_t model(int r, int c);
    res_t e;
    int gx, gy, ax, ay, m, d;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1]) - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]) - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    m  = (ax + ay > 255) ? 255 : ax + ay;
`ifdef CANNY_SOBEL_DIR_EN
    if (gx == 0 && gy == 0) d = 0;
    else if (5*ay < 2*ax)   d = 0;
    else if (2*ay > 5*ax)   d = 2;
    else if ((gx < 0) == (gy < 0)) d = 1;
    else d = 3;
`else
    d = 0;
`endif
    e.mag = 8'(m);
    e.dir = 2'(d);
    e.eol = (c == IMG_W - 2);
    e.eof = (c == IMG_W - 2) && (r == IMG_H - 2);
    return e;
  endfunction

  function automatic logic [7:0] pix_of(int kind, int r, int c);
    case (kind)
      0: return 8'd100;
      1: return (c >= 4) ? 8'd10 : 8'd0;
      2: return (r >= 3) ? 8'd10 : 8'd0;
      3: return (c >= 4) ? 8'd255 : 8'd0;
      4: return (c > r) ? 8'd10 : 8'd0;
      default: return 8'((r*53 + c*29 + r*c*7) & 255);
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    res_t got, e;
    if (!reset && out_valid && out_ready) begin
      got = {out_mag, out_dir, out_eol, out_eof};
      log_q.push_back(got);
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow got mag=%0d dir=%0d", got.mag, got.dir);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        assert (got === e) else begin
          n_fail++;
          $error("FAIL result[%0d] got mag=%0d dir=%0d eol=%0b eof=%0b want mag=%0d dir=%0d eol=%0b eof=%0b",
                 log_q.size() - 1, got.mag, got.dir, got.eol, got.eof, e.mag, e.dir, e.eol, e.eof);
        end
      end
    end
  end

  task automatic drive_pixel(input logic [7:0] p, input logic sof);
    int   tries;
    logic acc;
    tries = 0;
    acc   = 1'b0;
    in_valid = 1'b1;
    in_pix   = p;
    in_sof   = sof;
    while (!acc && tries < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (acc) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = int'(p);
      if (mr >= 2 && mc >= 2) exp_q.push_back(model(mr - 1, mc - 1));
      mc++;
      if (mc == IMG_W) begin
        mc = 0;
        mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic drive_frame(input int kind, input int stop_r, input int stop_c);
    bit stop;
    stop = 1'b0;
    for (int r = 0; r < IMG_H && !stop; r++) begin
      for (int c = 0; c < IMG_W && !stop; c++) begin
        drive_pixel(pix_of(kind, r, c), (r == 0 && c == 0));
        if (r == stop_r && c == stop_c) stop = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int kind, input string tag);
    log_q.delete();
    drive_frame(kind, -1, -1);
    drain(tag);
    check({tag, "_count"}, log_q.size(), NRES);
  endtask

  task automatic compare_ref(input string tag);
    for (int i = 0; i < NRES; i++) begin
      if (i < log_q.size() && i < ref_q.size()) check(tag, int'(log_q[i]), int'(ref_q[i]));
      else check({tag, "_missing"}, i, -1);
    end
  endtask

  task automatic stall_seq();
    int         t;
    logic [7:0] m0;
    logic [1:0] d0;
    repeat (20) @(posedge clk);
    #1;
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_found_valid", int'(out_valid), 1);
    out_ready = 1'b0;
    m0 = out_mag;
    d0 = out_dir;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_mag", int'(out_mag), int'(m0));
      check("stall_dir", int'(out_dir), int'(d0));
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    int k, f;
    n_tests   = 0;
    n_fail    = 0;
    mr        = 0;
    mc        = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_mag", int'(out_mag), 0);
    check("rst_out_dir", int'(out_dir), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_out_eof", int'(out_eof), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_frame(0, "flat");
    k = 0;
    f = 0;
    foreach (log_q[i]) begin
      k += int'(log_q[i].eol);
      f += int'(log_q[i].eof);
    end
    check("flat_eol_cnt", k, 4);
    check("flat_eof_cnt", f, 1);
    check("flat_eol_6", int'(log_q[5].eol), 1);
    check("flat_eol_12", int'(log_q[11].eol), 1);
    check("flat_eof_24", int'(log_q[23].eof), 1);
    check("flat_mag_0", int'(log_q[0].mag), 0);

    run_frame(1, "vstep");
    check("vstep_c3_mag", int'(log_q[2].mag), 40);
    check("vstep_c3_dir", int'(log_q[2].dir), 0);
    check("vstep_c4_mag", int'(log_q[3].mag), 40);
    check("vstep_c1_mag", int'(log_q[0].mag), 0);

    run_frame(2, "hstep");
    check("hstep_r1_mag", int'(log_q[0].mag), 0);
    check("hstep_r2_mag", int'(log_q[6].mag), 40);
    check("hstep_r2_dir", int'(log_q[6].dir), DIR_H);
    check("hstep_r3_mag", int'(log_q[12].mag), 40);

    run_frame(3, "sat");
    check("sat_mag", int'(log_q[2].mag), 255);

    run_frame(4, "diag");
    check("diag_22_mag", int'(log_q[7].mag), 60);
    check("diag_22_dir", int'(log_q[7].dir), DIR_D);
    check("diag_33_dir", int'(log_q[14].dir), DIR_D);

    run_frame(5, "pattern");
    ref_q = log_q;

    log_q.delete();
    fork
      drive_frame(5, -1, -1);
      stall_seq();
    join
    drain("stall");
    check("stall_count", log_q.size(), NRES);
    compare_ref("stall_vs_ref");

    drive_frame(5, 3, 4);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame(5, "post_rst");
    compare_ref("post_rst_vs_ref");

    drive_frame(2, 2, 5);
    drain("partial");
    run_frame(5, "sof_restart");
    compare_ref("sof_restart_vs_ref");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/canny_sobel_stream.md
Name: canny_sobel_stream

Overview:
- Parametrised streaming gradient stage for the canny_advanced pipeline, successor to the fixed-size in-core gradient logic.
- Accepts a raster-order grayscale pixel stream and buffers two image lines internally.
- Forms a 3x3 window and emits, per interior pixel, the Sobel magnitude |Gx|+|Gy| (saturated) and a 2-bit quantised direction.
- Uses valid/ready handshakes on both sides so it can sit between the pixel source and non-max suppression.

Parameters:
PIX_W, 8, input pixel width (unsigned)
IMG_W, 640, image width in pixels (>=3)
IMG_H, 480, image height in lines (>=3)
MAG_W, 8, output magnitude width; result saturates to 2^MAG_W-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel this cycle
in_pix  input  PIX_W  pixel value
in_sof  input  1  pixel is first of frame (row 0, col 0)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mag  output  MAG_W  saturated |Gx|+|Gy|
out_dir  output  2  0=0deg, 1=45deg, 2=90deg, 3=135deg
out_eol  output  1  last interior result of a row
out_eof  output  1  last interior result of the frame

Behaviour:
- Clock/reset: one clock clk; reset asynchronous, active-high. While reset is high, out_valid, out_mag, out_dir, out_eol, out_eof, row/col counters and window registers are 0. in_ready is 1 after reset.
- Handshakes:
  - Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (single output register; no combinational path from in_valid to in_ready).
- Position counters:
  - col counts 0..IMG_W-1, row counts 0..IMG_H-1, both advanced on accept. col wraps to 0 and increments row; row wraps to 0 after the last pixel.
  - An accept with in_sof=1 forces that pixel to (0,0) regardless of counter state. A partial frame is silently abandoned, with no outputs for its unfinished rows.
- Line buffers: two IMG_W-deep buffers, lb1 (line y-2) and lb0 (line y-1), indexed by col. On accept, {lb1[col], lb0[col], in_pix} shifts into the 3-column window, lb1[col]<=lb0[col] and lb0[col]<=in_pix.
- Output generation:
  - When the accepted pixel has row>=2 and col>=2, the output register loads the result for centre (row-1, col-1) on the same edge. out_valid rises the next cycle (latency 1).
  - Border pixels produce no output, giving exactly (IMG_W-2)*(IMG_H-2) results per frame.
  - If out_valid is set and out_ready is low, all out_* hold stable.
  - A transfer with no new load clears out_valid. A transfer with a simultaneous load keeps out_valid=1 with new data, so the block sustains 1 result/cycle.
- Arithmetic:
  - Gx = (p[0][2]+2p[1][2]+p[2][2]) - (p[0][0]+2p[1][0]+p[2][0]), where p[r][c] has r=top..bottom and c=left..right.
  - Gy = bottom row weighted sum - top row weighted sum.
  - Gx and Gy are signed PIX_W+3 bits. Magnitude is computed in PIX_W+3 bits unsigned, then saturated to MAG_W.
- Direction (ax=|Gx|, ay=|Gy|):
  - 5*ay < 2*ax -> 0.
  - Else if 2*ay > 5*ax -> 2.
  - Else if sign(Gx)==sign(Gy) -> 1, otherwise 3.
  - Gx=Gy=0 -> 0.
- out_eol = centre col == IMG_W-2. out_eof = centre row == IMG_H-2 and out_eol.
- Reset asserted mid-frame: everything clears at once, and the next frame must start with in_sof.

Optional Feature:
CANNY_SOBEL_DIR_EN
- Defined: direction logic present and out_dir driven as above.
- Undefined: direction logic removed and out_dir tied to 2'b00. Magnitude, timing and handshakes are unchanged.

Test Plan:
- Each scenario uses PIX_W=8, IMG_W=8, IMG_H=6, MAG_W=8.
- Flat frame, all pixels 100, in_sof on first pixel, out_ready=1 -> exactly 24 results, all mag 0 dir 0; out_eol on results 6,12,18,24; out_eof only on result 24.
- Vertical step: cols 0-3 = 0, cols 4-7 = 10 -> centre cols 3 and 4 give mag 40 dir 0 on every interior row; all other results mag 0.
- Horizontal step: rows 0-2 = 0, rows 3-5 = 10 -> centre rows 2 and 3 give mag 40 dir 2; with the macro undefined, dir is 0 throughout.
- Saturation: vertical step 0 to 255 -> Gx=1020, out_mag=255. Diagonal step (pixel = 10 if col>row else 0) -> mag>0 and dir 3 (Gx>0, Gy<0) on the diagonal.
- Backpressure: drop out_ready for 5 cycles while out_valid=1 -> out_valid, out_mag and out_dir stay stable, in_ready=0 and no pixel is lost. The full 24-result sequence matches the no-stall run.
- Reset/resync:
  - Assert reset during row 3 -> out_valid=0 within the same cycle, in_ready=1. A new in_sof frame then yields 24 correct results.
  - Separately, in_sof mid-frame -> counters restart and 24 results follow.
